// File: rtl/mvm_dp_sequencer_if.sv
// Command port of the MVM datapath sequencer: the instruction decoder
// (master) hands one matrix-vector job to the sequencer (slave).
//
// Handshake: the master drives i_cmd_valid with stable fields; the command
// transfers on the rising clk edge where i_cmd_valid && o_cmd_ready. The
// slave raises o_cmd_ready only while it is idle, and o_cmd_ready never
// depends on i_cmd_valid.
interface mvm_dp_sequencer_if #(
  parameter int ADDRW  = 9,
  parameter int VADDRW = 9,
  parameter int WADDRW = 10,
  parameter int CNTW   = 9
) ();
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [ADDRW:0]    i_cmd_rows;
  logic [CNTW-1:0]   i_cmd_chunks;
  logic              i_cmd_reduce;
  logic [VADDRW-1:0] i_cmd_vbase;
  logic [WADDRW-1:0] i_cmd_wbase;

  modport master (
    output i_cmd_valid, i_cmd_rows, i_cmd_chunks, i_cmd_reduce,
           i_cmd_vbase, i_cmd_wbase,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd_rows, i_cmd_chunks, i_cmd_reduce,
           i_cmd_vbase, i_cmd_wbase,
    output o_cmd_ready
  );
endinterface

// File: rtl/mvm_dp_sequencer.sv
// Sequencer for one MVM datapath lane: walks the vector RF and weight memory
// for a rows x chunks job, tags each beat for the datapath one cycle later so
// the tags line up with the read data, then counts returned results.
module mvm_dp_sequencer #(
  parameter int ADDRW  = 9,
  parameter int VADDRW = 9,
  parameter int WADDRW = 10,
  parameter int CNTW   = 9
) (
  input  logic               clk,
  input  logic               rst,
  mvm_dp_sequencer_if.slave  cmd,
  input  logic               i_stall,
  output logic               o_vrf_rd_en,
  output logic [VADDRW-1:0]  o_vrf_rd_addr,
  output logic               o_wmem_rd_en,
  output logic [WADDRW-1:0]  o_wmem_rd_addr,
  output logic               o_dp_valid,
  output logic               o_dp_accum,
  output logic               o_dp_last,
  output logic               o_dp_reduce,
  output logic [ADDRW-1:0]   o_dp_accum_addr,
  input  logic               i_dp_result_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [1:0]         o_dbg_state
);
  localparam int MEM_DEPTH = 2 ** ADDRW;
  localparam logic [ADDRW:0] MAX_ROWS = (ADDRW + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDRW:0]    rows_q, rows_d;
  logic [CNTW-1:0]   chunks_q, chunks_d;
  logic              reduce_q, reduce_d;
  logic [VADDRW-1:0] vbase_q, vbase_d;
  logic [WADDRW-1:0] wptr_q, wptr_d;
  logic [CNTW-1:0]   c_q, c_d;
  logic [ADDRW-1:0]  r_q, r_d;
  logic [ADDRW:0]    results_q, results_d;
  logic              err_q, err_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_accum_q, dp_accum_d;
  logic              dp_last_q, dp_last_d;
  logic              dp_reduce_q, dp_reduce_d;
  logic [ADDRW-1:0]  dp_addr_q, dp_addr_d;

  logic              rd_en;
  logic              result_inc;
  logic              cmd_legal;
  logic              row_end;
  logic              chunk_end;
  logic [ADDRW:0]    rows_m1;
  logic [CNTW-1:0]   chunks_m1;

  // Next-state, counter and beat-tag logic. Reads are issued combinationally
  // so a stall suppresses the read in the same cycle it is raised.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    chunks_d    = chunks_q;
    reduce_d    = reduce_q;
    vbase_d     = vbase_q;
    wptr_d      = wptr_q;
    c_d         = c_q;
    r_d         = r_q;
    err_d       = err_q;

    rows_m1     = rows_q - (ADDRW + 1)'(1);
    chunks_m1   = chunks_q - CNTW'(1);
    row_end     = ({1'b0, r_q} == rows_m1);
    chunk_end   = (c_q == chunks_m1);
    rd_en       = (state_q == S_ISSUE) && !i_stall && !rst;
    result_inc  = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && i_dp_result_valid;
    results_d   = results_q + {{ADDRW{1'b0}}, result_inc};
    cmd_legal   = (cmd.i_cmd_rows != '0) && (cmd.i_cmd_chunks != '0) &&
                  (cmd.i_cmd_rows <= MAX_ROWS);

    // Tags travel with the beat; they are zero whenever no beat is issued.
    dp_valid_d  = rd_en;
    dp_accum_d  = rd_en && (c_q != '0);
    dp_last_d   = rd_en && chunk_end;
    dp_reduce_d = rd_en && reduce_q;
    dp_addr_d   = rd_en ? r_q : '0;

    case (state_q)
      S_IDLE: begin
        if (cmd.i_cmd_valid) begin
          rows_d    = cmd.i_cmd_rows;
          chunks_d  = cmd.i_cmd_chunks;
          reduce_d  = cmd.i_cmd_reduce;
          vbase_d   = cmd.i_cmd_vbase;
          wptr_d    = cmd.i_cmd_wbase;
          c_d       = '0;
          r_d       = '0;
          results_d = '0;
          err_d     = !cmd_legal;
          state_d   = cmd_legal ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (rd_en) begin
          wptr_d = wptr_q + WADDRW'(1);
          if (row_end) begin
            r_d = '0;
            c_d = c_q + CNTW'(1);
            if (chunk_end) state_d = S_DRAIN;
          end else begin
            r_d = r_q + ADDRW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (results_d >= rows_q) state_d = S_DONE;
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered datapath controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      chunks_q    <= '0;
      reduce_q    <= 1'b0;
      vbase_q     <= '0;
      wptr_q      <= '0;
      c_q         <= '0;
      r_q         <= '0;
      results_q   <= '0;
      err_q       <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_accum_q  <= 1'b0;
      dp_last_q   <= 1'b0;
      dp_reduce_q <= 1'b0;
      dp_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      chunks_q    <= chunks_d;
      reduce_q    <= reduce_d;
      vbase_q     <= vbase_d;
      wptr_q      <= wptr_d;
      c_q         <= c_d;
      r_q         <= r_d;
      results_q   <= results_d;
      err_q       <= err_d;
      dp_valid_q  <= dp_valid_d;
      dp_accum_q  <= dp_accum_d;
      dp_last_q   <= dp_last_d;
      dp_reduce_q <= dp_reduce_d;
      dp_addr_q   <= dp_addr_d;
    end
  end

  // Output decode; everything is held quiet while reset is asserted.
  always_comb begin
    cmd.o_cmd_ready = (state_q == S_IDLE) && !rst;
    o_vrf_rd_en     = rd_en;
    o_wmem_rd_en    = rd_en;
    o_vrf_rd_addr   = rd_en ? (vbase_q + VADDRW'(c_q)) : '0;
    o_wmem_rd_addr  = rd_en ? wptr_q : '0;
    o_dp_valid      = dp_valid_q;
    o_dp_accum      = dp_accum_q;
    o_dp_last       = dp_last_q;
    o_dp_reduce     = dp_reduce_q;
    o_dp_accum_addr = dp_addr_q;
    o_busy          = (state_q != S_IDLE) && !rst;
    o_done          = (state_q == S_DONE) && !rst;
    o_err           = (state_q == S_DONE) && !rst && err_q;
    o_dbg_state     = state_q;
  end
endmodule

// File: tb/tb_mvm_dp_sequencer.sv
// Directed bench for mvm_dp_sequencer: a negedge monitor records every read
// beat, datapath beat, done pulse and command acceptance; each test task
// drives a scenario and compares the recordings against expected values.
module tb_mvm_dp_sequencer;
  localparam int ADDRW  = 9;
  localparam int VADDRW = 9;
  localparam int WADDRW = 10;
  localparam int CNTW   = 9;
  localparam int TW     = ADDRW + 3;
  localparam int BW     = VADDRW + WADDRW + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_stall = 1'b0;
  logic              i_dp_result_valid = 1'b0;
  logic              o_vrf_rd_en, o_wmem_rd_en;
  logic [VADDRW-1:0] o_vrf_rd_addr;
  logic [WADDRW-1:0] o_wmem_rd_addr;
  logic              o_dp_valid, o_dp_accum, o_dp_last, o_dp_reduce;
  logic [ADDRW-1:0]  o_dp_accum_addr;
  logic              o_busy, o_done, o_err;
  logic [1:0]        o_dbg_state;

  mvm_dp_sequencer_if #(.ADDRW(ADDRW), .VADDRW(VADDRW), .WADDRW(WADDRW), .CNTW(CNTW)) cmd_if ();

  mvm_dp_sequencer #(.ADDRW(ADDRW), .VADDRW(VADDRW), .WADDRW(WADDRW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .i_stall(i_stall),
    .o_vrf_rd_en(o_vrf_rd_en), .o_vrf_rd_addr(o_vrf_rd_addr),
    .o_wmem_rd_en(o_wmem_rd_en), .o_wmem_rd_addr(o_wmem_rd_addr),
    .o_dp_valid(o_dp_valid), .o_dp_accum(o_dp_accum), .o_dp_last(o_dp_last),
    .o_dp_reduce(o_dp_reduce), .o_dp_accum_addr(o_dp_accum_addr),
    .i_dp_result_valid(i_dp_result_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- monitor ----------------
  int                rd_cyc_q[$];
  logic [VADDRW-1:0] va_q[$];
  logic [WADDRW-1:0] wa_q[$];
  int                dp_cyc_q[$];
  logic [TW-1:0]     tag_q[$];
  int                done_cyc_q[$];
  logic              done_err_q[$];
  int                acc_cyc_q[$];
  int                en_split = 0;

  always @(negedge clk) begin
    if (o_vrf_rd_en) begin
      rd_cyc_q.push_back(cyc);
      va_q.push_back(o_vrf_rd_addr);
      wa_q.push_back(o_wmem_rd_addr);
    end
    if (o_dp_valid) begin
      dp_cyc_q.push_back(cyc);
      tag_q.push_back({o_dp_accum_addr, o_dp_accum, o_dp_last, o_dp_reduce});
    end
    if (o_done) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(o_err);
    end
    if (cmd_if.i_cmd_valid && cmd_if.o_cmd_ready) acc_cyc_q.push_back(cyc);
    if (o_vrf_rd_en !== o_wmem_rd_en) en_split++;
  end

  task automatic clear_mon();
    rd_cyc_q.delete(); va_q.delete(); wa_q.delete();
    dp_cyc_q.delete(); tag_q.delete();
    done_cyc_q.delete(); done_err_q.delete(); acc_cyc_q.delete();
  endtask

  // ---------------- scoreboard model ----------------
  logic [BW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  // Expected beat records {vrf addr, weight addr, accum_addr, accum, last,
  // reduce} and read cycles, skipping stalled cycles counted from acceptance.
  task automatic model_job(input int rows, input int chunks, input logic reduce,
                           input int vbase, input int wbase, input int acc,
                           input int stall_at, input int stall_len);
    logic [VADDRW-1:0] va;
    logic [WADDRW-1:0] wa;
    logic [ADDRW-1:0]  ra;
    int b, k;
    exp_q.delete();
    exp_cyc_q.delete();
    b = 0;
    k = 1;
    for (int c = 0; c < chunks; c++) begin
      for (int r = 0; r < rows; r++) begin
        va = VADDRW'(vbase + c);
        wa = WADDRW'(wbase + b);
        ra = ADDRW'(r);
        exp_q.push_back({va, wa, ra, (c != 0), (c == chunks - 1), reduce});
        while (k >= stall_at && k < stall_at + stall_len) k++;
        exp_cyc_q.push_back(acc + k);
        k++;
        b++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input int rows, input int chunks, input logic reduce,
                          input int vbase, input int wbase, input bit keep_valid,
                          output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    cmd_if.i_cmd_rows   = (ADDRW + 1)'(rows);
    cmd_if.i_cmd_chunks = CNTW'(chunks);
    cmd_if.i_cmd_reduce = reduce;
    cmd_if.i_cmd_vbase  = VADDRW'(vbase);
    cmd_if.i_cmd_wbase  = WADDRW'(wbase);
    cmd_if.i_cmd_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_if.o_cmd_ready) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_if.i_cmd_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept_timeout: got no o_cmd_ready within 50 cycles, expected acceptance");
    end
  endtask

  task automatic run_issue(input int nbeats, input int stall_at, input int stall_len);
    for (int k = 1; k <= nbeats + stall_len + 2; k++) begin
      i_stall = (k >= stall_at) && (k < stall_at + stall_len);
      @(posedge clk);
      #1;
    end
    i_stall = 1'b0;
  endtask

  task automatic send_results(input int n, output int last);
    last = -1;
    for (int i = 0; i < n; i++) begin
      i_dp_result_valid = 1'b1;
      last = cyc;
      @(posedge clk);
      #1;
    end
    i_dp_result_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cmd_if.o_cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready_during: got %0b expected 0", cmd_if.o_cmd_ready);
    end
    n_checks++;
    if ({o_vrf_rd_en, o_dp_valid, o_busy, o_done, o_err} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs_during: got %05b expected 00000",
               {o_vrf_rd_en, o_dp_valid, o_busy, o_done, o_err});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_if.o_cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready_after: got %0b expected 1", cmd_if.o_cmd_ready);
    end
    n_checks++;
    if ({o_vrf_rd_en, o_wmem_rd_en, o_dp_valid, o_dp_accum, o_dp_last, o_dp_reduce,
         o_dp_accum_addr, o_busy, o_done, o_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs_after: got nonzero outputs, expected all zero");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_job();
    int acc, last, oc;
    logic [BW-1:0] obs;
    clear_mon();
    send_cmd(4, 3, 1'b1, 'h10, 'h100, 1'b0, acc);
    run_issue(12, 0, 0);
    send_results(4, last);
    idle(2);
    model_job(4, 3, 1'b1, 'h10, 'h100, acc, 0, 0);
    n_checks++;
    if (dp_cyc_q.size() !== 12) begin
      n_errors++;
      $display("FAIL basic_beat_count: got %0d expected 12", dp_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < dp_cyc_q.size() && i < rd_cyc_q.size()) ? {va_q[i], wa_q[i], tag_q[i]} : 'x;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_errors++;
        $display("FAIL basic_beat_%0d: got %h expected %h", i, obs, exp_q[i]);
      end
      oc = (i < dp_cyc_q.size()) ? dp_cyc_q[i] : -1;
      n_checks++;
      if (oc !== exp_cyc_q[i] + 1) begin
        n_errors++;
        $display("FAIL basic_dp_cycle_%0d: got %0d expected %0d", i, oc, exp_cyc_q[i] + 1);
      end
    end
    n_checks++;
    if (wa_q.size() == 12 ? (wa_q[11] !== 10'h10B || va_q[4] !== 9'h011) : 1'b1) begin
      n_errors++;
      $display("FAIL basic_hand_addr: last waddr/5th vaddr wrong, expected 10B/011");
    end
    n_checks++;
    if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== last + 1)) begin
      n_errors++;
      $display("FAIL basic_done: got %0d pulses (first at %0d) expected 1 at %0d",
               done_cyc_q.size(), done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, last + 1);
    end
    n_checks++;
    if (done_err_q.size() > 0 && done_err_q[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_err: got 1 expected 0");
    end
  endtask

  task automatic test_stall();
    int acc, last, oc;
    logic [BW-1:0] obs;
    clear_mon();
    send_cmd(4, 3, 1'b1, 'h10, 'h100, 1'b0, acc);
    run_issue(12, 6, 3);
    send_results(4, last);
    idle(2);
    model_job(4, 3, 1'b1, 'h10, 'h100, acc, 6, 3);
    n_checks++;
    if (dp_cyc_q.size() !== 12 || rd_cyc_q.size() !== 12) begin
      n_errors++;
      $display("FAIL stall_beat_count: got %0d/%0d expected 12/12", rd_cyc_q.size(), dp_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < dp_cyc_q.size() && i < rd_cyc_q.size()) ? {va_q[i], wa_q[i], tag_q[i]} : 'x;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_errors++;
        $display("FAIL stall_beat_%0d: got %h expected %h", i, obs, exp_q[i]);
      end
      oc = (i < rd_cyc_q.size()) ? rd_cyc_q[i] : -1;
      n_checks++;
      if (oc !== exp_cyc_q[i]) begin
        n_errors++;
        $display("FAIL stall_rd_cycle_%0d: got %0d expected %0d", i, oc, exp_cyc_q[i]);
      end
    end
    oc = (dp_cyc_q.size() > 5) ? dp_cyc_q[5] - dp_cyc_q[4] : -1;
    n_checks++;
    if (oc !== 4) begin
      n_errors++;
      $display("FAIL stall_gap: got spacing %0d expected 4", oc);
    end
    n_checks++;
    if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== last + 1)) begin
      n_errors++;
      $display("FAIL stall_done: got %0d pulses expected 1 at %0d", done_cyc_q.size(), last + 1);
    end
  endtask

  task automatic test_wrap();
    int acc, last;
    logic [WADDRW-1:0] w0, w1;
    logic [TW-1:0] t0, t1;
    clear_mon();
    send_cmd(1, 1, 1'b0, 'h5, 'h3FF, 1'b0, acc);
    run_issue(1, 0, 0);
    send_results(1, last);
    idle(2);
    w0 = (wa_q.size() > 0) ? wa_q[0] : 'x;
    t0 = (tag_q.size() > 0) ? tag_q[0] : 'x;
    n_checks++;
    if (dp_cyc_q.size() !== 1 || w0 !== 10'h3FF || t0 !== {9'd0, 1'b0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL wrap_single: got n=%0d waddr=%h tag=%h expected n=1 waddr=3ff tag=002",
               dp_cyc_q.size(), w0, t0);
    end
    n_checks++;
    if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== last + 1)) begin
      n_errors++;
      $display("FAIL wrap_single_done: got %0d pulses expected 1 at %0d", done_cyc_q.size(), last + 1);
    end
    clear_mon();
    send_cmd(2, 1, 1'b0, 'h5, 'h3FF, 1'b0, acc);
    run_issue(2, 0, 0);
    send_results(2, last);
    idle(2);
    w0 = (wa_q.size() > 1) ? wa_q[0] : 'x;
    w1 = (wa_q.size() > 1) ? wa_q[1] : 'x;
    t1 = (tag_q.size() > 1) ? tag_q[1] : 'x;
    n_checks++;
    if (w0 !== 10'h3FF || w1 !== 10'h000) begin
      n_errors++;
      $display("FAIL wrap_waddr: got %h,%h expected 3ff,000", w0, w1);
    end
    n_checks++;
    if (t1 !== {9'd1, 1'b0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL wrap_tag1: got %h expected %h", t1, {9'd1, 1'b0, 1'b1, 1'b0});
    end
    n_checks++;
    if (done_cyc_q.size() !== 1) begin
      n_errors++;
      $display("FAIL wrap_pair_done: got %0d pulses expected 1", done_cyc_q.size());
    end
  endtask

  task automatic test_illegal();
    int rows_v[3]   = '{0, 4, 513};
    int chunks_v[3] = '{1, 0, 1};
    int acc;
    for (int i = 0; i < 3; i++) begin
      clear_mon();
      send_cmd(rows_v[i], chunks_v[i], 1'b0, 'h0, 'h0, 1'b0, acc);
      idle(3);
      n_checks++;
      if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== acc + 1)) begin
        n_errors++;
        $display("FAIL illegal_%0d_done: got %0d pulses (first %0d) expected 1 at %0d", i,
                 done_cyc_q.size(), done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, acc + 1);
      end
      n_checks++;
      if (done_err_q.size() == 0 || done_err_q[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL illegal_%0d_err: got no err with done, expected 1", i);
      end
      n_checks++;
      if (rd_cyc_q.size() !== 0 || dp_cyc_q.size() !== 0) begin
        n_errors++;
        $display("FAIL illegal_%0d_activity: got %0d reads %0d dp beats expected 0 0",
                 i, rd_cyc_q.size(), dp_cyc_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int acc, last, oc;
    logic [BW-1:0] obs;
    clear_mon();
    send_cmd(4, 3, 1'b1, 'h10, 'h100, 1'b0, acc);
    idle(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_vrf_rd_en, o_wmem_rd_en, o_dp_valid, o_dp_accum, o_dp_last, o_dp_reduce,
         o_dp_accum_addr, o_busy, o_done, o_err, o_dbg_state} !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got nonzero outputs after reset, expected all zero");
    end
    n_checks++;
    if (cmd_if.o_cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_ready: got %0b expected 1", cmd_if.o_cmd_ready);
    end
    @(posedge clk);
    #1;
    clear_mon();
    send_results(4, last);
    idle(3);
    n_checks++;
    if (done_cyc_q.size() !== 0) begin
      n_errors++;
      $display("FAIL midrst_stray_done: got %0d done pulses expected 0", done_cyc_q.size());
    end
    clear_mon();
    send_cmd(2, 2, 1'b0, 'h20, 'h50, 1'b0, acc);
    run_issue(4, 0, 0);
    send_results(2, last);
    idle(2);
    model_job(2, 2, 1'b0, 'h20, 'h50, acc, 0, 0);
    n_checks++;
    if (dp_cyc_q.size() !== 4) begin
      n_errors++;
      $display("FAIL midrst_job_count: got %0d expected 4", dp_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < dp_cyc_q.size() && i < rd_cyc_q.size()) ? {va_q[i], wa_q[i], tag_q[i]} : 'x;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_errors++;
        $display("FAIL midrst_beat_%0d: got %h expected %h", i, obs, exp_q[i]);
      end
      oc = (i < dp_cyc_q.size()) ? dp_cyc_q[i] : -1;
      n_checks++;
      if (oc !== exp_cyc_q[i] + 1) begin
        n_errors++;
        $display("FAIL midrst_dp_cycle_%0d: got %0d expected %0d", i, oc, exp_cyc_q[i] + 1);
      end
    end
    n_checks++;
    if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== last + 1)) begin
      n_errors++;
      $display("FAIL midrst_job_done: got %0d pulses expected 1 at %0d", done_cyc_q.size(), last + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, last, oc;
    clear_mon();
    send_cmd(2, 1, 1'b0, 'h0, 'h200, 1'b1, acc1);
    // Second command presented immediately; valid stays high throughout.
    cmd_if.i_cmd_rows   = 10'd3;
    cmd_if.i_cmd_chunks = 9'd1;
    cmd_if.i_cmd_vbase  = 9'h030;
    cmd_if.i_cmd_wbase  = 10'h300;
    idle(3);
    // Results at acc1+4, +5 finish job 1; the one at +6 lands in DONE.
    send_results(3, last);
    @(posedge clk);
    #1;
    cmd_if.i_cmd_valid = 1'b0;
    oc = (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1;
    n_checks++;
    if (oc !== acc1 + 6) begin
      n_errors++;
      $display("FAIL b2b_done1: got %0d expected %0d", oc, acc1 + 6);
    end
    oc = (acc_cyc_q.size() > 1) ? acc_cyc_q[1] : -1;
    n_checks++;
    if (oc !== acc1 + 7) begin
      n_errors++;
      $display("FAIL b2b_accept2: got %0d expected %0d", oc, acc1 + 7);
    end
    idle(4);
    n_checks++;
    if (rd_cyc_q.size() !== 5 || wa_q[2] !== 10'h300 || va_q[2] !== 9'h030 || wa_q[4] !== 10'h302) begin
      n_errors++;
      $display("FAIL b2b_job2_reads: got %0d reads, expected 5 with job2 waddr 300..302 vaddr 030",
               rd_cyc_q.size());
    end
    done_cyc_q.delete();
    done_err_q.delete();
    send_results(2, last);
    idle(2);
    n_checks++;
    if (done_cyc_q.size() !== 0) begin
      n_errors++;
      $display("FAIL b2b_early_done: got %0d pulses after 2 of 3 results expected 0", done_cyc_q.size());
    end
    send_results(1, last);
    idle(2);
    n_checks++;
    if (done_cyc_q.size() !== 1 || (done_cyc_q.size() > 0 && done_cyc_q[0] !== last + 1)) begin
      n_errors++;
      $display("FAIL b2b_done2: got %0d pulses expected 1 at %0d", done_cyc_q.size(), last + 1);
    end
    n_checks++;
    if (en_split !== 0) begin
      n_errors++;
      $display("FAIL rd_en_pair: got %0d cycles with differing rd_en expected 0", en_split);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cmd_if.i_cmd_valid  = 1'b0;
    cmd_if.i_cmd_rows   = '0;
    cmd_if.i_cmd_chunks = '0;
    cmd_if.i_cmd_reduce = 1'b0;
    cmd_if.i_cmd_vbase  = '0;
    cmd_if.i_cmd_wbase  = '0;
    test_reset();
    test_basic_job();
    test_stall();
    test_wrap();
    test_illegal();
    test_reset_mid_job();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mvm_dp_sequencer.md
# mvm_dp_sequencer

Command-driven sequencer for a single MVM datapath lane. It accepts one matrix-vector job, walks the vector register file and the weight memory, and drives the datapath's valid, accumulate-address, accumulate, last and reduce controls so that they arrive cycle-aligned with the memory read data. It then counts returned results and reports job completion. It sits between the MVM top-level instruction decoder and the datapath/memory pair.

## Interface
- ADDRW, 9, accumulation memory address width; MEM_DEPTH = 2**ADDRW
- VADDRW, 9, vector register file address width
- WADDRW, 10, weight memory address width
- CNTW, 9, width of chunk count
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready; high only in IDLE
- i_cmd_rows  in  ADDRW+1  output rows per job, legal 1..MEM_DEPTH
- i_cmd_chunks  in  CNTW  input-vector chunks per job, legal ≥1
- i_cmd_reduce  in  1  reduce enable for the whole job
- i_cmd_vbase  in  VADDRW  vector RF base address
- i_cmd_wbase  in  WADDRW  weight memory base address
- i_stall  in  1  downstream back-pressure; blocks issue
- o_vrf_rd_en / o_vrf_rd_addr  out  1 / VADDRW  vector RF read (1-cycle read latency)
- o_wmem_rd_en / o_wmem_rd_addr  out  1 / WADDRW  weight memory read (1-cycle read latency)
- o_dp_valid, o_dp_accum, o_dp_last, o_dp_reduce  out  1 each  datapath controls
- o_dp_accum_addr  out  ADDRW  datapath accumulation address
- i_dp_result_valid  in  1  datapath output valid, used for result counting
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  single-cycle job-complete pulse
- o_err  out  1  single-cycle pulse with o_done for an illegal command

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - o_cmd_ready=1.
  - On i_cmd_valid: latch all command fields and clear the counters (chunk c=0, row r=0, issued=0, results=0).
  - Legal command: go to ISSUE.
  - rows==0, chunks==0 or rows>MEM_DEPTH: go to DONE with the error flag set. No reads and no datapath activity.
- **ISSUE**, each cycle with i_stall=0:
  - Issue one beat: rd_en=1 on both memories.
  - vrf addr = vbase+c. The weight address starts at wbase and increments by 1 per beat, wrapping modulo 2**WADDRW.
  - Beat tags: accum_addr=r, accum=(c!=0), last=(c==chunks-1), reduce=cmd_reduce.
  - r increments. When r reaches rows-1, r wraps to 0 and c increments.
  - After the final beat (c==chunks-1 and r==rows-1), go to DRAIN.
  - With i_stall=1: no issue, both rd_en=0, counters hold.
- Datapath controls are the beat tags registered one cycle, so they align with the read data. o_dp_valid is the registered rd_en.
- **Result counting** is active in ISSUE and DRAIN: each i_dp_result_valid increments results. i_dp_result_valid in IDLE or DONE is ignored.
- **DRAIN**: when results reaches rows (including the count made in this cycle), go to DONE.
- **DONE**
  - o_done=1 for one cycle; o_err=1 if the error flag is set.
  - Go to IDLE next cycle; the error flag clears.
- Counter widths: rows and results use ADDRW+1 bits; issued uses ADDRW+1+CNTW bits. No overflow is possible for legal commands.

## Timing
- Reset values: o_cmd_ready=0 during reset and 1 in the first cycle after reset. All other outputs are 0 during and after reset.
- A command is accepted on the cycle with i_cmd_valid & o_cmd_ready. The first rd_en occurs on the next cycle.
- First o_dp_valid is 2 cycles after acceptance.
- With no stalls, ISSUE lasts exactly rows*chunks cycles and o_dp_valid is high for exactly rows*chunks consecutive cycles.
- o_done is asserted the cycle after the cycle in which the rows-th result is counted.
- For an illegal command, o_done and o_err are asserted 1 cycle after acceptance.
- A stall asserted in cycle t suppresses rd_en in cycle t, and therefore o_dp_valid in cycle t+1. Stall has no effect outside ISSUE.
- rst high mid-job:
  - Next cycle: state IDLE, counters 0, all outputs 0 except o_cmd_ready.
  - No o_done is generated.
  - Datapath results still in flight are ignored.
- A new command cannot be accepted in the cycle o_done is high. The earliest next acceptance is the following cycle.

## Test plan
- rows=4, chunks=3, vbase=0x10, wbase=0x100, reduce=1, no stall:
  - Exactly 12 consecutive o_dp_valid.
  - Accum_addr sequence 0,1,2,3 repeated 3 times.
  - accum=0 for the first 4 beats; last=1 only for beats 9-12.
  - Weight addresses 0x100..0x10B; vrf addresses 0x10×4, 0x11×4, 0x12×4.
  - o_done one cycle after the 4th i_dp_result_valid.
- Same job with i_stall high for 3 cycles mid-row: no beat is lost or duplicated, the address sequence is identical, and o_dp_valid has a 3-cycle gap.
- rows=1, chunks=1, wbase=0x3FF: a single beat with accum=0 and last=1 at weight address 0x3FF. Repeat with rows=2, chunks=1: the second beat wraps to weight address 0x000.
- Illegal commands rows=0, then chunks=0, then rows=MEM_DEPTH+1: each gives o_done=o_err=1 one cycle after acceptance and no rd_en.
- rst asserted during ISSUE of a 4×3 job:
  - Outputs clear the next cycle.
  - Subsequent i_dp_result_valid pulses produce no o_done.
  - A new 2×2 job then completes normally.
- Back-to-back commands with i_cmd_valid held high: the second command is accepted on the cycle after o_done, and results from job 1 are not counted toward job 2.
